mem_access_stage: RTL and testbench

- Memory stage directly downstream of the ALU: consumes ALU_result, the funct3/opcode and read_data2 of the executing instruction.
- Load/store ops: drives a data-memory request/ready handshake, with byte-lane steering, sign/zero extension and a misalignment check.
- All other ops: ALU_result passes through unchanged to writeback.
- Output is one registered writeback packet per accepted instruction.

---
 rtl/mem_access_stage.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory stage after the ALU: issues load/store requests, applies byte-lane steering and sign/zero extension, or passes ALU results straight through.
// Latency: 1 cycle for non-memory and fault paths; k+1 cycles when mem_ready arrives k cycles after acceptance.
// Backpressure: in_ready is high only in IDLE, so upstream holds in_valid until accepted; the memory side waits for mem_ready or times out.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault
);

  localparam logic [6:0] LP_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] LP_OP_STORE = 7'b0100011;
  // The access is aborted on the cycle the wait counter would reach TIMEOUT.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_wstrb;
  logic [31:0] r_mem_wdata;
  logic        r_wb_valid;
  logic        r_wb_we;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_fault;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_ld_legal;
  logic        w_st_legal;
  logic        w_misaligned;
  logic        w_bad;
  logic [3:0]  w_st_wstrb;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  // Decode of the presented instruction: class, legality, alignment and store lane encoding.
  always_comb begin
    w_is_load    = (opcode == LP_OP_LOAD);
    w_is_store   = (opcode == LP_OP_STORE);
    w_ld_legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
    w_st_legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    w_misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   w_misaligned = alu_result[0];
      2'b10:   w_misaligned = |alu_result[1:0];
      default: w_misaligned = 1'b0;
    endcase
    w_bad = (w_is_load && (!w_ld_legal || w_misaligned)) ||
            (w_is_store && (!w_st_legal || w_misaligned));
    w_st_wstrb = 4'b1111;
    w_st_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_st_wstrb = 4'b0001 << alu_result[1:0];
        w_st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_st_wstrb = 4'b0011 << alu_result[1:0];
        w_st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_st_wstrb = 4'b1111;
        w_st_wdata = store_data;
      end
    endcase
  end

  // Lane selection and sign/zero extension of the returned load word.
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'h0, w_byte};
      3'b101:  w_load_val = {16'h0, w_half};
      default: w_load_val = mem_rdata;
    endcase
  end

  // Stage FSM with all outputs registered; reset drops any in-flight request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_funct3    <= '0;
      r_lane      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wb_valid <= 1'b0;
          if (in_valid) begin
            r_wb_rd  <= rd;
            r_funct3 <= funct3;
            r_lane   <= alu_result[1:0];
            r_cnt    <= '0;
            if (w_bad) begin
              r_state    <= S_RESP;
              r_wb_valid <= 1'b1;
              r_wb_we    <= 1'b0;
              r_wb_data  <= '0;
              r_fault    <= 1'b1;
            end else if (w_is_load || w_is_store) begin
              r_state     <= S_ACCESS;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_store;
              r_mem_addr  <= {alu_result[31:2], 2'b00};
              r_mem_wstrb <= w_is_store ? w_st_wstrb : 4'b0000;
              r_mem_wdata <= w_is_store ? w_st_wdata : 32'h0;
            end else begin
              r_state    <= S_RESP;
              r_wb_valid <= 1'b1;
              r_wb_we    <= (rd != 5'd0);
              r_wb_data  <= alu_result;
              r_fault    <= 1'b0;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            r_state     <= S_RESP;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= '0;
            r_wb_valid  <= 1'b1;
            r_fault     <= 1'b0;
            r_wb_we     <= !r_mem_we && (r_wb_rd != 5'd0);
            r_wb_data   <= r_mem_we ? 32'h0 : w_load_val;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state     <= S_RESP;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= '0;
            r_wb_valid  <= 1'b1;
            r_fault     <= 1'b1;
            r_wb_we     <= 1'b0;
            r_wb_data   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_wb_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_wb_valid <= 1'b0;
          r_mem_req  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_we     = r_wb_we;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign fault     = r_fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: passthrough, loads, stores, faults, timeout and reset.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  mem_access_stage #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .rd         (rd),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge; returns just after the accepting edge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                       input logic [31:0] alu, input logic [31:0] sd);
    in_valid   = 1'b1;
    opcode     = op;
    funct3     = f3;
    rd         = r;
    alu_result = alu;
    store_data = sd;
    step();
    in_valid   = 1'b0;
  endtask

  // Hold mem_ready low for nwait ACCESS cycles, then complete with rdata.
  task automatic mem_resp(input int nwait, input logic [31:0] rdata);
    for (int i = 0; i < nwait; i++) step();
    mem_ready = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] exp);
    issue(OP_LOAD, f3, 5'd7, alu, 32'h0);
    chk({tag, "_req"}, mem_req, 1'b1);
    mem_resp(0, rdata);
    chk({tag, "_wbv"}, wb_valid, 1'b1);
    chk({tag, "_data"}, wb_data, exp);
    step();
  endtask

  int req_cycles;
  int wbv_seen;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    opcode     = 7'h0;
    funct3     = 3'h0;
    rd         = 5'h0;
    alu_result = 32'h0;
    store_data = 32'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // ALU passthrough
    issue(OP_ALU, 3'b000, 5'd3, 32'd15, 32'h0);
    chk("alu_wbv", wb_valid, 1'b1);
    chk("alu_data", wb_data, 32'd15);
    chk("alu_we", wb_we, 1'b1);
    chk("alu_rd", wb_rd, 32'd3);
    chk("alu_fault", fault, 1'b0);
    chk("alu_noreq", mem_req, 1'b0);
    chk("alu_busy", in_ready, 1'b0);
    step();
    chk("alu_wbv_drop", wb_valid, 1'b0);
    chk("alu_idle", in_ready, 1'b1);

    // LW with two wait cycles
    issue(OP_LOAD, 3'b010, 5'd5, 32'd112, 32'h0);
    chk("lw_req", mem_req, 1'b1);
    chk("lw_addr", mem_addr, 32'd112);
    chk("lw_wstrb", mem_wstrb, 4'b0000);
    chk("lw_we", mem_we, 1'b0);
    chk("lw_wbv_early", wb_valid, 1'b0);
    mem_resp(2, 32'hDEADBEEF);
    chk("lw_wbv", wb_valid, 1'b1);
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_wbwe", wb_we, 1'b1);
    chk("lw_req_drop", mem_req, 1'b0);
    step();
    chk("lw_wbv_drop", wb_valid, 1'b0);

    // Sub-word loads
    do_load("lb", 3'b000, 32'd103, 32'h80FF_0000, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'd103, 32'h80FF_0000, 32'h00000080);
    do_load("lh", 3'b001, 32'd102, 32'h80FF_0000, 32'hFFFF80FF);
    do_load("lhu", 3'b101, 32'd102, 32'h80FF_0000, 32'h000080FF);
    do_load("lb0", 3'b000, 32'd100, 32'h1234_5678, 32'h00000078);

    // SB
    issue(OP_STORE, 3'b000, 5'd9, 32'd101, 32'h12345678);
    chk("sb_addr", mem_addr, 32'd100);
    chk("sb_wstrb", mem_wstrb, 4'b0010);
    chk("sb_wdata", mem_wdata, 32'h78787878);
    chk("sb_we", mem_we, 1'b1);
    mem_resp(0, 32'h0);
    chk("sb_wbv", wb_valid, 1'b1);
    chk("sb_wbwe", wb_we, 1'b0);
    chk("sb_data", wb_data, 32'h0);
    step();

    // SH
    issue(OP_STORE, 3'b001, 5'd9, 32'd102, 32'h12345678);
    chk("sh_addr", mem_addr, 32'd100);
    chk("sh_wstrb", mem_wstrb, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'h56785678);
    mem_resp(1, 32'h0);
    chk("sh_wbwe", wb_we, 1'b0);
    step();

    // SW
    issue(OP_STORE, 3'b010, 5'd9, 32'd108, 32'hA5A5_0F0F);
    chk("sw_wstrb", mem_wstrb, 4'b1111);
    chk("sw_wdata", mem_wdata, 32'hA5A5_0F0F);
    mem_resp(0, 32'h0);
    step();

    // Misaligned LW
    issue(OP_LOAD, 3'b010, 5'd5, 32'd114, 32'h0);
    chk("mis_wbv", wb_valid, 1'b1);
    chk("mis_fault", fault, 1'b1);
    chk("mis_wbwe", wb_we, 1'b0);
    chk("mis_noreq", mem_req, 1'b0);
    step();

    // Illegal load funct3
    issue(OP_LOAD, 3'b011, 5'd5, 32'd0, 32'h0);
    chk("ill_fault", fault, 1'b1);
    chk("ill_noreq", mem_req, 1'b0);
    step();

    // Timeout: mem_ready never comes
    issue(OP_LOAD, 3'b000, 5'd4, 32'd100, 32'h0);
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      req_cycles++;
      step();
    end
    chk("to_req_cycles", req_cycles, 32'd15);
    chk("to_wbv", wb_valid, 1'b1);
    chk("to_fault", fault, 1'b1);
    chk("to_wbwe", wb_we, 1'b0);
    step();

    // mem_ready on the last permitted cycle wins over timeout
    issue(OP_LOAD, 3'b010, 5'd6, 32'd100, 32'h0);
    mem_resp(14, 32'hCAFEF00D);
    chk("tw_wbv", wb_valid, 1'b1);
    chk("tw_fault", fault, 1'b0);
    chk("tw_data", wb_data, 32'hCAFEF00D);
    step();

    // Held-off instruction behind a busy cycle
    issue(OP_ALU, 3'b000, 5'd1, 32'd1, 32'h0);
    in_valid   = 1'b1;
    rd         = 5'd9;
    alu_result = 32'd77;
    step();
    chk("hold_idle_wbv", wb_valid, 1'b0);
    step();
    in_valid = 1'b0;
    chk("hold_wbv", wb_valid, 1'b1);
    chk("hold_rd", wb_rd, 32'd9);
    chk("hold_data", wb_data, 32'd77);
    step();

    // Reset during ACCESS
    issue(OP_LOAD, 3'b010, 5'd5, 32'd100, 32'h0);
    chk("rma_req", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rma_req_async", mem_req, 1'b0);
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_2222;
    step();
    step();
    rst_n = 1'b1;
    wbv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (wb_valid) wbv_seen++;
      step();
    end
    mem_ready = 1'b0;
    chk("rma_no_wbv", wbv_seen, 32'd0);
    chk("rma_ready", in_ready, 1'b1);

    // Load to x0
    issue(OP_LOAD, 3'b010, 5'd0, 32'd100, 32'h0);
    mem_resp(0, 32'h0000_1234);
    chk("x0_wbv", wb_valid, 1'b1);
    chk("x0_wbwe", wb_we, 1'b0);
    chk("x0_data", wb_data, 32'h0000_1234);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
